// File: rtl/mem_access_unit.sv
// Memory-stage controller: drives the data-memory req/ack port, stalls the front
// of the pipeline while an access is outstanding and feeds MEM/WB (bubbles while waiting).
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic [63:0] address,
  input  logic [63:0] writeData,
  input  logic [4:0]  Rd,
  input  logic [1:0]  MemToReg,
  input  logic        RegWrite,
  input  logic        ChooseRd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  output logic [1:0]  dm_size,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata,
  output logic [63:0] memData,
  output logic [63:0] addressout,
  output logic [4:0]  Rdout,
  output logic [1:0]  MemToRegout,
  output logic        RegWriteout,
  output logic        ChooseRdout,
  output logic        stall,
  output logic        fault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [63:0]   r_addr, r_wdata, r_data;
  logic [1:0]    r_size, r_memtoreg;
  logic [4:0]    r_rd;
  logic          r_we, r_regwrite, r_chooserd;
  logic          mem_op, misaligned, timed_out;
  logic          stall_c, fault_c;

  function automatic logic [63:0] zext(input logic [63:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {56'b0, d[7:0]};
      2'b01:   return {48'b0, d[15:0]};
      2'b10:   return {32'b0, d[31:0]};
      default: return d;
    endcase
  endfunction

  assign mem_op = valid & (MemRead | MemWrite);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    misaligned = 1'b0;
    case (size)
      2'b01:   misaligned = address[0];
      2'b10:   misaligned = |address[1:0];
      2'b11:   misaligned = |address[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // An ack in the same cycle the counter saturates still wins over the timeout.
  assign timed_out = (state == WAIT) && !dm_ack && (wait_cnt == CW'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_size     <= '0;
      r_memtoreg <= '0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_regwrite <= 1'b0;
      r_chooserd <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_op && !misaligned) begin
          state      <= WAIT;
          wait_cnt   <= '0;
          r_addr     <= address;
          r_size     <= size;
          r_wdata    <= zext(writeData, size);
          r_we       <= MemWrite;
          r_rd       <= Rd;
          r_memtoreg <= MemToReg;
          r_regwrite <= RegWrite;
          r_chooserd <= ChooseRd;
          r_data     <= '0;
        end
        WAIT: begin
          if (dm_ack) begin
            r_data <= r_we ? 64'd0 : zext(dm_rdata, r_size);
            state  <= DONE;
          end else if (timed_out) begin
            r_data     <= '0;
            r_regwrite <= 1'b0;
            state      <= DONE;
          end else begin
            // Only reached below TIMEOUT, so the increment saturates there.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_req   = (state == WAIT);
  assign dm_we    = r_we;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;
  assign dm_size  = r_size;

  always_comb begin
    addressout  = r_addr;
    Rdout       = r_rd;
    ChooseRdout = r_chooserd;
    MemToRegout = 2'b00;
    RegWriteout = 1'b0;
    memData     = '0;
    stall_c     = 1'b0;
    fault_c     = 1'b0;
    case (state)
      IDLE: begin
        addressout  = address;
        Rdout       = Rd;
        ChooseRdout = ChooseRd;
        if (mem_op) begin
          fault_c = misaligned;
          stall_c = !misaligned;
        end else begin
          MemToRegout = MemToReg;
          RegWriteout = RegWrite & valid;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        fault_c = timed_out;
      end
      DONE: begin
        MemToRegout = r_memtoreg;
        RegWriteout = r_regwrite;
        memData     = r_data;
      end
      default: ;
    endcase
  end

  // In IDLE these depend on live inputs, so reset masks them to drop without a clock.
  assign stall = stall_c & reset;
  assign fault = fault_c & reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: pass-through, load, store,
// misalignment, timeout and asynchronous reset during an outstanding access.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid, MemRead, MemWrite, RegWrite, ChooseRd, dm_ack;
  logic [1:0]  size, MemToReg;
  logic [63:0] address, writeData, dm_rdata;
  logic [4:0]  Rd;
  logic        dm_req, dm_we, RegWriteout, ChooseRdout, stall, fault;
  logic [63:0] dm_addr, dm_wdata, memData, addressout;
  logic [1:0]  dm_size, MemToRegout;
  logic [4:0]  Rdout;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .size(size), .address(address), .writeData(writeData), .Rd(Rd), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ChooseRd(ChooseRd), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .memData(memData), .addressout(addressout), .Rdout(Rdout),
    .MemToRegout(MemToRegout), .RegWriteout(RegWriteout), .ChooseRdout(ChooseRdout),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; MemRead = 0; MemWrite = 0; size = 0; address = 0; writeData = 0;
    Rd = 0; MemToReg = 0; RegWrite = 0; ChooseRd = 0; dm_ack = 0; dm_rdata = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #2;
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL rst_dm_req: got %0h want 0", dm_req); end
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL rst_dm_we: got %0h want 0", dm_we); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0h want 0", stall); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %0h want 0", fault); end
    n_cmp++; if (memData !== 64'd0) begin n_err++; $display("FAIL rst_memData: got %0h want 0", memData); end
    n_cmp++; if (dm_addr !== 64'd0) begin n_err++; $display("FAIL rst_dm_addr: got %0h want 0", dm_addr); end
    n_cmp++; if (dm_wdata !== 64'd0) begin n_err++; $display("FAIL rst_dm_wdata: got %0h want 0", dm_wdata); end
    n_cmp++; if (dm_size !== 2'd0) begin n_err++; $display("FAIL rst_dm_size: got %0h want 0", dm_size); end
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_non_mem();
    tick();
    valid = 1; Rd = 5'd5; RegWrite = 1; address = 64'h40; MemToReg = 2'd2; ChooseRd = 1;
    dm_ack = 1; dm_rdata = 64'hFFFF;
    #1;
    n_cmp++; if (Rdout !== 5'd5) begin n_err++; $display("FAIL nm_Rdout: got %0h want 5", Rdout); end
    n_cmp++; if (RegWriteout !== 1'b1) begin n_err++; $display("FAIL nm_RegWriteout: got %0h want 1", RegWriteout); end
    n_cmp++; if (addressout !== 64'h40) begin n_err++; $display("FAIL nm_addressout: got %0h want 40", addressout); end
    n_cmp++; if (MemToRegout !== 2'd2) begin n_err++; $display("FAIL nm_MemToRegout: got %0h want 2", MemToRegout); end
    n_cmp++; if (ChooseRdout !== 1'b1) begin n_err++; $display("FAIL nm_ChooseRdout: got %0h want 1", ChooseRdout); end
    n_cmp++; if (memData !== 64'd0) begin n_err++; $display("FAIL nm_memData: got %0h want 0", memData); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nm_stall: got %0h want 0", stall); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL nm_dm_req: got %0h want 0", dm_req); end
    tick();
    n_cmp++; if (dm_req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL nm_stray_ack: got req=%0h stall=%0h want 0/0", dm_req, stall); end
    // Invalid slot: RegWrite is masked and a memory op is not started.
    valid = 0; MemRead = 1; dm_ack = 0;
    #1;
    n_cmp++; if (RegWriteout !== 1'b0) begin n_err++; $display("FAIL nv_RegWriteout: got %0h want 0", RegWriteout); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nv_stall: got %0h want 0", stall); end
    idle_inputs();
  endtask

  task automatic test_load_word();
    int stall_cycles = 0;
    tick();
    valid = 1; MemRead = 1; size = 2'b10; address = 64'h100; Rd = 5'd7;
    MemToReg = 2'd1; RegWrite = 1; ChooseRd = 1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_stall_n: got %0h want 1", stall); end
    n_cmp++; if (RegWriteout !== 1'b0) begin n_err++; $display("FAIL lw_bubble_n: got %0h want 0", RegWriteout); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL lw_req_n: got %0h want 0", dm_req); end
    if (stall) stall_cycles++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall) stall_cycles++;
      n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL lw_req_wait%0d: got %0h want 1", i, dm_req); end
      n_cmp++; if (RegWriteout !== 1'b0) begin n_err++; $display("FAIL lw_bubble_wait%0d: got %0h want 0", i, RegWriteout); end
      n_cmp++; if (dm_addr !== 64'h100 || dm_size !== 2'b10 || dm_we !== 1'b0) begin
        n_err++; $display("FAIL lw_req_fields%0d: got addr=%0h size=%0h we=%0h want 100/2/0", i, dm_addr, dm_size, dm_we); end
    end
    tick();
    if (stall) stall_cycles++;
    dm_ack = 1; dm_rdata = 64'hFFFF_FFFF_8765_4321;
    tick();
    if (stall) stall_cycles++;
    idle_inputs();
    #1;
    n_cmp++; if (memData !== 64'h0000_0000_8765_4321) begin n_err++; $display("FAIL lw_memData: got %0h want 87654321", memData); end
    n_cmp++; if (Rdout !== 5'd7) begin n_err++; $display("FAIL lw_Rdout: got %0h want 7", Rdout); end
    n_cmp++; if (RegWriteout !== 1'b1) begin n_err++; $display("FAIL lw_RegWriteout: got %0h want 1", RegWriteout); end
    n_cmp++; if (MemToRegout !== 2'd1) begin n_err++; $display("FAIL lw_MemToRegout: got %0h want 1", MemToRegout); end
    n_cmp++; if (addressout !== 64'h100) begin n_err++; $display("FAIL lw_addressout: got %0h want 100", addressout); end
    n_cmp++; if (stall_cycles != 5) begin n_err++; $display("FAIL lw_stall_cycles: got %0d want 5", stall_cycles); end
    tick();
    n_cmp++; if (stall !== 1'b0 || memData !== 64'd0) begin n_err++; $display("FAIL lw_back_idle: got stall=%0h memData=%0h want 0/0", stall, memData); end
  endtask

  task automatic test_store_byte();
    tick();
    valid = 1; MemWrite = 1; size = 2'b00; address = 64'h7; writeData = 64'hABCD; Rd = 5'd3;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_n: got %0h want 1", stall); end
    tick();
    n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL sb_req: got %0h want 1", dm_req); end
    n_cmp++; if (dm_we !== 1'b1) begin n_err++; $display("FAIL sb_we: got %0h want 1", dm_we); end
    n_cmp++; if (dm_addr !== 64'h7) begin n_err++; $display("FAIL sb_addr: got %0h want 7", dm_addr); end
    n_cmp++; if (dm_size !== 2'b00) begin n_err++; $display("FAIL sb_size: got %0h want 0", dm_size); end
    n_cmp++; if (dm_wdata !== 64'hCD) begin n_err++; $display("FAIL sb_wdata: got %0h want cd", dm_wdata); end
    dm_ack = 1; dm_rdata = 64'hFFFF;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (memData !== 64'd0) begin n_err++; $display("FAIL sb_memData: got %0h want 0", memData); end
    n_cmp++; if (stall !== 1'b0 || dm_req !== 1'b0) begin n_err++; $display("FAIL sb_done: got stall=%0h req=%0h want 0/0", stall, dm_req); end
  endtask

  task automatic test_misaligned();
    tick();
    valid = 1; MemRead = 1; size = 2'b11; address = 64'h104; RegWrite = 1; Rd = 5'd4; MemToReg = 2'd1;
    #1;
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %0h want 1", fault); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %0h want 0", dm_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %0h want 0", stall); end
    n_cmp++; if (RegWriteout !== 1'b0 || MemToRegout !== 2'd0) begin n_err++; $display("FAIL mis_bubble: got rw=%0h m2r=%0h want 0/0", RegWriteout, MemToRegout); end
    n_cmp++; if (Rdout !== 5'd4) begin n_err++; $display("FAIL mis_Rdout: got %0h want 4", Rdout); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (fault !== 1'b0 || dm_req !== 1'b0) begin n_err++; $display("FAIL mis_after: got fault=%0h req=%0h want 0/0", fault, dm_req); end
  endtask

  task automatic test_timeout();
    int faults = 0;
    tick();
    valid = 1; MemRead = 1; size = 2'b11; address = 64'h200; RegWrite = 1; Rd = 5'd9;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL to_stall_n: got %0h want 1", stall); end
    for (int i = 0; i < 17; i++) begin
      tick();
      if (fault) faults++;
      n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL to_req%0d: got %0h want 1", i, dm_req); end
      n_cmp++; if (fault !== (i == 16)) begin n_err++; $display("FAIL to_fault%0d: got %0h want %0h", i, fault, (i == 16)); end
    end
    n_cmp++; if (faults != 1) begin n_err++; $display("FAIL to_fault_count: got %0d want 1", faults); end
    tick();
    dm_ack = 1; dm_rdata = 64'h1234_5678;
    #1;
    n_cmp++; if (memData !== 64'd0) begin n_err++; $display("FAIL to_memData: got %0h want 0", memData); end
    n_cmp++; if (RegWriteout !== 1'b0) begin n_err++; $display("FAIL to_RegWriteout: got %0h want 0", RegWriteout); end
    n_cmp++; if (stall !== 1'b0 || fault !== 1'b0 || dm_req !== 1'b0) begin
      n_err++; $display("FAIL to_done: got stall=%0h fault=%0h req=%0h want 0/0/0", stall, fault, dm_req); end
    tick();
    valid = 0; MemRead = 0;
    #1;
    n_cmp++; if (stall !== 1'b0 || dm_req !== 1'b0 || memData !== 64'd0) begin
      n_err++; $display("FAIL to_late_ack: got stall=%0h req=%0h memData=%0h want 0/0/0", stall, dm_req, memData); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    tick();
    valid = 1; MemRead = 1; size = 2'b10; address = 64'h300; RegWrite = 1; Rd = 5'd9;
    tick();
    n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL rw_req_before: got %0h want 1", dm_req); end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL rw_req_async: got %0h want 0", dm_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rw_stall_async: got %0h want 0", stall); end
    idle_inputs();
    tick(); tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (dm_req !== 1'b0 || dm_we !== 1'b0 || stall !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL rw_ctrl_rel: got req=%0h we=%0h stall=%0h fault=%0h want 0", dm_req, dm_we, stall, fault); end
    n_cmp++; if (dm_addr !== 64'd0 || dm_wdata !== 64'd0 || dm_size !== 2'd0 || memData !== 64'd0) begin
      n_err++; $display("FAIL rw_data_rel: got addr=%0h wdata=%0h size=%0h memData=%0h want 0", dm_addr, dm_wdata, dm_size, memData); end
    tick();
    valid = 1; MemRead = 1; size = 2'b01; address = 64'h302; RegWrite = 1; Rd = 5'd12; MemToReg = 2'd1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rw_next_stall: got %0h want 1", stall); end
    tick();
    n_cmp++; if (dm_req !== 1'b1 || dm_addr !== 64'h302 || dm_size !== 2'b01) begin
      n_err++; $display("FAIL rw_next_req: got req=%0h addr=%0h size=%0h want 1/302/1", dm_req, dm_addr, dm_size); end
    dm_ack = 1; dm_rdata = 64'hFFFF_FFFF_FFFF_BEEF;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (memData !== 64'hBEEF) begin n_err++; $display("FAIL rw_next_memData: got %0h want beef", memData); end
    n_cmp++; if (Rdout !== 5'd12 || RegWriteout !== 1'b1 || stall !== 1'b0) begin
      n_err++; $display("FAIL rw_next_done: got rd=%0h rw=%0h stall=%0h want c/1/0", Rdout, RegWriteout, stall); end
    tick();
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_load_word();
    test_store_byte();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and drives the data-memory port with a req/ack handshake. It stalls earlier stages while an access is outstanding and emits bubbles into MEM/WB during the stall. It presents load data and the passthrough control fields for MEM/WB to capture.

## Interface
- `TIMEOUT`, 16: maximum WAIT cycles without `dm_ack` before a fault is raised.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `valid` in 1: EX/MEM holds a real instruction.
- `MemRead`, `MemWrite` in 1 each: access type; both set is treated as a write.
- `size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `address` in 64: effective address from the ALU.
- `writeData` in 64: store data, right-justified.
- `Rd` in 5, `MemToReg` in 2, `RegWrite` in 1, `ChooseRd` in 1: control fields from EX/MEM.
- `dm_req` out 1: memory request; held until ack.
- `dm_we` out 1: write request.
- `dm_addr` out 64: request address.
- `dm_wdata` out 64: store data with bits above `size` zeroed.
- `dm_size` out 2: request size.
- `dm_ack` in 1: one-cycle completion pulse.
- `dm_rdata` in 64: load data, right-justified; valid when `dm_ack`=1.
- `memData` out 64: load data zero-extended per size; 0 for non-loads.
- `addressout` out 64, `Rdout` out 5, `MemToRegout` out 2, `RegWriteout` out 1, `ChooseRdout` out 1: fields to MEM/WB.
- `stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `fault` out 1: one-cycle pulse on a misaligned access or a timeout.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE, no memory op** (`valid`=0, or MemRead=MemWrite=0)
  - All outputs pass through combinationally; `memData`=0; `stall`=0.
  - `RegWriteout` = `RegWrite` & `valid`.
- **IDLE, misaligned op** (address low bits nonzero for the given size: half bit0, word bits1:0, dword bits2:0)
  - `fault`=1 that cycle; no request is issued; `stall`=0.
  - `RegWriteout`=0, `MemToRegout`=0; the other fields pass through.
- **IDLE, aligned op**
  - `stall`=1.
  - Register addr, size, masked wdata, we, Rd, MemToReg, RegWrite and ChooseRd.
  - Go to WAIT.
  - Outputs carry a bubble: `RegWriteout`=0, `MemToRegout`=0.
- **WAIT**
  - `dm_req`=1; the request fields come from registers and stay stable until ack.
  - `stall`=1; outputs carry a bubble.
  - On `dm_ack`: capture `dm_rdata` zero-extended by the registered size (read only; writes capture 0). Go to DONE.
  - If the wait counter reaches `TIMEOUT` with no ack: `fault`=1, captured data=0, registered RegWrite cleared, go to DONE.
  - A late ack after the timeout is ignored.
- **DONE**
  - `stall`=0.
  - Outputs come from the registered fields plus captured `memData`; MEM/WB captures them on this edge.
  - Go to IDLE. EX/MEM advances on the same edge.
- **Reset** (`reset`=0)
  - State goes to IDLE immediately; all registers clear.
  - `dm_req`, `stall` and `fault` drop asynchronously, including mid-WAIT.
  - The memory must tolerate a dropped request.
- Wait counter: 0 on entry to WAIT, +1 per WAIT cycle without ack, saturating.

## Timing
- Reset values: `dm_req`=0, `dm_we`=0, `stall`=0, `fault`=0, `memData`=0, `dm_addr`=0, `dm_wdata`=0, `dm_size`=0, all registered fields 0.
- Non-memory op: zero added latency.
- Memory op presented in cycle N:
  - `stall` is high in N and N+1.
  - `dm_req` is high from N+1.
  - Ack in N+1+k puts the unit in DONE in N+2+k.
  - Total stall cycles = 2 + k.
- `dm_ack` while `dm_req`=0 is ignored.
- `fault` never lasts longer than one cycle.

## Test plan
- Non-memory op: `valid`=1, `MemRead`=`MemWrite`=0, Rd=5, RegWrite=1, address=0x40.
  - Required: same cycle, Rdout=5, RegWriteout=1, addressout=0x40, memData=0, stall=0, dm_req never asserted.
- Load word: address=0x100, size=10, memory acks after 3 WAIT cycles with dm_rdata=0xFFFF_FFFF_8765_4321.
  - Required: stall high for 5 cycles.
  - Required: in DONE, memData=0x0000_0000_8765_4321, Rdout correct, RegWriteout=1.
  - Required: during the stall, RegWriteout=0.
- Store byte: address=0x7, writeData=0xABCD.
  - Required in WAIT: dm_we=1, dm_addr=0x7, dm_size=00, dm_wdata=0xCD.
  - Required in DONE after ack: memData=0.
- Misaligned dword load at 0x104.
  - Required same cycle: fault=1, dm_req=0, stall=0, RegWriteout=0.
- Timeout: dm_ack never asserted, TIMEOUT=16.
  - Required: fault pulses once after 16 WAIT cycles, then DONE with memData=0 and RegWriteout=0.
  - Required: a late ack has no effect.
- Reset pulled low mid-WAIT.
  - Required: dm_req and stall fall without waiting for a clock edge.
  - Required after reset release: IDLE, all outputs at reset values, and the next op completes normally.
